// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Start bit low, 8 data bits LSB first, stop bit high.
// Optional feature macro: UART_RX_FRAME_ERR_EN. When it is defined, a low stop bit pulses
// frame_err and drops the byte. When it is undefined, the stop bit is ignored and
// frame_err is tied low.
module uart_rx #(
    parameter int unsigned CYCLES_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out,
    output logic       done,
    output logic       frame_err
);

    localparam logic [15:0] HALF_M1 = 16'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic       sync1_q;
    logic       rx_s_q;
    state_e     state_q;
    logic [15:0] cycles_q;
    logic [2:0] idx_q;
    logic [7:0] shift_q;
    logic [7:0] out_q;
    logic       done_q;
    logic       fall;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // The falling edge is detected one stage early, so START is entered on the
    // same edge where rx_s first reads 0. That edge is the timing reference.
    assign fall = rx_s_q & ~sync1_q;

`ifdef UART_RX_FRAME_ERR_EN
    logic frame_err_q;
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    // Receive FSM: bit timing, data capture and the registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cycles_q    <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            out_q       <= 8'h00;
            done_q      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    cycles_q <= 16'd0;
                    if (fall) state_q <= StStart;
                end
                StStart: begin
                    if (cycles_q == HALF_M1) begin
                        cycles_q <= 16'd0;
                        idx_q    <= 3'd0;
                        // A line that is high again at mid-start is a glitch.
                        state_q  <= rx_s_q ? StIdle : StData;
                    end else begin
                        cycles_q <= cycles_q + 16'd1;
                    end
                end
                StData: begin
                    if (cycles_q == BIT_M1) begin
                        cycles_q       <= 16'd0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) state_q <= StStop;
                        else               idx_q   <= idx_q + 3'd1;
                    end else begin
                        cycles_q <= cycles_q + 16'd1;
                    end
                end
                StStop: begin
                    if (cycles_q == BIT_M1) begin
                        // Leave at mid-stop so an immediately following start bit is caught.
                        cycles_q <= 16'd0;
                        state_q  <= StIdle;
`ifdef UART_RX_FRAME_ERR_EN
                        if (rx_s_q) begin
                            out_q  <= shift_q;
                            done_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
`else
                        out_q  <= shift_q;
                        done_q <= 1'b1;
`endif
                    end else begin
                        cycles_q <= cycles_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

- Receives 8N1 serial frames and presents each received byte on a parallel output with a one-cycle `done` strobe.
- Serial format: one start bit (low), 8 data bits LSB first, one stop bit (high). Idle line is high.
- It is the receiving end of the same 8N1 link the design's UART transmitter drives, and it sits between the board's serial RX pin and the byte-consuming logic.
- It uses the same bit period, in clock cycles, as the transmitter.

## Interface
Parameters:
- `CYCLES_PER_BIT`, default 104. Clock cycles per serial bit. Must be ≥ 4 and ≤ 65535.

Ports:
- `clk` input, 1 bit. Single clock. All state updates on its rising edge.
- `rst` input, 1 bit. Reset is asynchronous and active-high.
- `rx` input, 1 bit. Serial line, asynchronous to `clk`.
- `out` output, 8 bits. Last correctly received byte. Holds its value until the next good frame.
- `done` output, 1 bit. High for exactly one cycle when `out` is updated.
- `frame_err` output, 1 bit. High for exactly one cycle when the stop bit is sampled low. Tied 0 unless `UART_RX_FRAME_ERR_EN` is defined.

## Operation
- Input sync: `rx` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1.
- Counters:
  - 16-bit `cycles` counter.
  - 3-bit bit index.
  - `HALF = CYCLES_PER_BIT/2`, integer division.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `cycles` is held at 0.
  - When a falling edge of `rx_s` is seen (previous 1, current 0), go to START.
  - A line held low does not re-arm the receiver; a new falling edge is required.
- START:
  - `cycles` increments every cycle.
  - At `cycles == HALF-1`, sample `rx_s`.
    - If 0: go to DATA, clear `cycles` and the bit index.
    - If 1: false start (glitch). Go to IDLE with no output activity.
- DATA:
  - At `cycles == CYCLES_PER_BIT-1`, sample `rx_s` into shift register bit [index] and clear `cycles`.
  - After index 7 is sampled, go to STOP. Otherwise increment the index.
- STOP:
  - At `cycles == CYCLES_PER_BIT-1`, sample `rx_s`.
    - If 1: register the shift register into `out`, pulse `done`, go to IDLE.
    - If 0: handled per Configuration, then go to IDLE.
- Data bits are LSB first, so the first bit received lands in `out[0]`.
- Back-to-back frames: IDLE is entered at mid-stop-bit, so a start bit immediately following the stop bit is accepted.
- Reset mid-frame:
  - The FSM returns to IDLE and the partial byte is discarded.
  - `out`, `done` and `frame_err` are cleared immediately.

## Timing
- Reset values:
  - `out` = 8'h00, `done` = 0, `frame_err` = 0.
  - FSM in IDLE, `cycles` = 0, synchronizer flops = 1.
- Let t0 be the clock edge at which `rx_s` first reads 0. This is 2 edges after `rx` falls.
- Start bit is validated at t0+HALF.
- Data bit k (k = 0..7) is sampled at t0+HALF+(k+1)·CYCLES_PER_BIT.
- Stop bit is sampled at tS = t0+HALF+9·CYCLES_PER_BIT.
- `out` changes and `done` (or `frame_err`) rises at edge tS. It falls at tS+1.
- A start glitch shorter than HALF cycles (as seen at `rx_s`) is rejected.
- `out` is stable at all times except at the edge where `done` rises.

## Configuration
- Macro: `UART_RX_FRAME_ERR_EN`.
- Defined:
  - A low stop bit pulses `frame_err` for one cycle.
  - `done` stays 0 and `out` is unchanged.
  - The FSM goes to IDLE. The next frame needs a new falling edge after the line returns high (break condition tolerated).
- Undefined:
  - The stop bit is sampled but ignored.
  - The byte is always delivered with a `done` pulse.
  - `frame_err` is constant 0.

## Test plan
- Send byte 0xA5 at CYCLES_PER_BIT=104 → `out`=8'hA5, `done` high exactly one cycle at t0+52+936. `frame_err`=0.
- Send 0x00 then 0xFF back-to-back, with no idle between the stop bit and the next start bit → two `done` pulses 1040 cycles apart. `out`=8'h00, then 8'hFF.
- Pulse `rx` low for 20 cycles, then high → no `done` and no `frame_err`. A following 0x3C frame is received correctly.
- Send 0x3C with stop bit forced low:
  - Macro defined → `frame_err` one-cycle pulse, `done`=0, `out` keeps its previous value.
  - Macro undefined → `done` pulse and `out`=8'h3C.
- Assert `rst` during data bit 4 of a 0x81 frame → outputs 0 immediately, no `done`. After release, a clean 0x55 frame yields `out`=8'h55.
- Sweep CYCLES_PER_BIT=4 and 65535 with byte 0x96 → correct `out` and `done` at the computed tS.
